// File: rtl/shift_stage16_pkg.sv
// Shared definitions for the 16-bit shift unit: datapath widths, shift
// opcodes and the register payloads carried between the pipeline stages.
package shift_stage16_pkg;

    localparam int WIDTH = 16;  // datapath width, fixed by the ISA
    localparam int SHW   = 4;   // shift-amount width, amounts 0..15

    // Shift opcodes as presented by decode.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,  // logical left, zero fill
        OP_SRL = 2'b01,  // logical right, zero fill
        OP_SRA = 2'b10,  // arithmetic right, sign fill
        OP_ROR = 2'b11   // rotate right
    } shift_op_e;

    // Operand register payload (S1).
    typedef struct packed {
        shift_op_e        op;
        logic [SHW-1:0]   shift;
        logic [WIDTH-1:0] data;
    } s1_payload_t;

    // Result register payload (S2).
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
        logic             carry;
    } s2_payload_t;

    // Mirror a word end-for-end so a left shift can reuse the right-shift path.
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage16_core.sv
// Combinational 16-bit barrel shifter built as a 4-level log shifter
// (1/2/4/8). Left shifts run through the right-shift path on a mirrored
// operand. A guard bit below the LSB catches the last bit shifted out,
// which becomes the carry.
module shift16_core
    import shift_stage16_pkg::*;
(
    input  shift_op_e        op,
    input  logic [SHW-1:0]   shift,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam logic [WIDTH:0] ALL_ONES = {(WIDTH+1){1'b1}};

    logic             mirror;     // operate on bit-reversed operand (SLL)
    logic             fill;       // bit shifted in from the top
    logic [WIDTH:0]   shift_acc;  // {word, guard} for SLL/SRL/SRA
    logic [WIDTH-1:0] rot_acc;    // word for ROR

    // Log-shifter: each set bit of the amount applies one power-of-two stage.
    always_comb begin
        // NOTE: every variable written in this block gets a default first, so
        // no path through the block can leave a value held and infer a latch.
        mirror    = (op == OP_SLL);
        fill      = (op == OP_SRA) && data[WIDTH-1];
        shift_acc = {(mirror ? bit_reverse(data) : data), 1'b0};
        rot_acc   = data;

        for (int lvl = 0; lvl < SHW; lvl++) begin
            if (shift[lvl]) begin
                shift_acc = (shift_acc >> (1 << lvl))
                          | (fill ? ~(ALL_ONES >> (1 << lvl)) : '0);
                rot_acc   = (rot_acc >> (1 << lvl))
                          | (rot_acc << (WIDTH - (1 << lvl)));
            end
        end
    end

    // Select the result path and the carry source for the opcode.
    always_comb begin
        result = shift_acc[WIDTH:1];
        carry  = shift_acc[0];
        case (op)
            OP_SLL: begin
                result = bit_reverse(shift_acc[WIDTH:1]);
                carry  = shift_acc[0];
            end
            OP_ROR: begin
                result = rot_acc;
                // A zero-amount rotate shifts nothing out.
                carry  = (shift != '0) && rot_acc[WIDTH-1];
            end
            default: begin
                result = shift_acc[WIDTH:1];
                carry  = shift_acc[0];
            end
        endcase
    end

endmodule

// File: rtl/shift_stage16.sv
// Execute-stage shift unit: an operand register (S1) feeding the
// combinational barrel shifter, and a result register (S2) toward writeback.
// Both stages share a valid/ready handshake so the unit runs at one
// operation per cycle and holds two operations under full backpressure.
module shift_stage16
    import shift_stage16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [SHW-1:0]   in_shift,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry
);

    logic        s1_valid_q, s1_valid_d;
    s1_payload_t s1_q, s1_d;
    logic        out_valid_q, out_valid_d;
    s2_payload_t s2_q, s2_d;

    logic             s2_advance;
    logic             in_fire;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;

    shift16_core u_core (
        .op     (s1_q.op),
        .shift  (s1_q.shift),
        .data   (s1_q.data),
        .result (core_result),
        .carry  (core_carry)
    );

    // Handshake: S2 can take a new value when empty or draining this cycle;
    // S1 can accept when empty or when it is moving into S2.
    always_comb begin
        s2_advance = !out_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_advance;
        in_fire    = in_valid && in_ready;
    end

    // S1 next state: load on accept, otherwise empty once moved into S2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s2_advance) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_d.op    = shift_op_e'(in_op);
            s1_d.shift = in_shift;
            s1_d.data  = in_data;
        end
    end

    // S2 next state: capture the shifter result and flags when advancing.
    always_comb begin
        out_valid_d = out_valid_q;
        s2_d        = s2_q;
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.data  = core_result;
                s2_d.zero  = (core_result == '0);
                s2_d.neg   = core_result[WIDTH-1];
                s2_d.carry = core_carry;
            end
        end
    end

    // Pipeline registers with synchronous reset discarding both stages.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            s2_q        <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            s2_q        <= s2_d;
        end
    end

    // Outputs come straight from the result register.
    always_comb begin
        out_valid = out_valid_q;
        out_data  = s2_q.data;
        out_zero  = s2_q.zero;
        out_neg   = s2_q.neg;
        out_carry = s2_q.carry;
    end

endmodule

// File: tb/tb_shift_stage16.sv
// Self-checking bench for shift_stage16: directed cases with known answers,
// stream and backpressure scenarios, reset mid-flight, and a randomized
// phase scored against a queue-based behavioural model.
module tb_shift_stage16;
    import shift_stage16_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [3:0]  in_shift;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic        out_neg;
    logic        out_carry;

    always #5 clk = ~clk;

    shift_stage16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_shift  (in_shift),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_carry (out_carry)
    );

    typedef struct {
        logic [15:0] data;
        logic        zero;
        logic        neg;
        logic        carry;
        int          age;   // clock edges since acceptance
    } exp_t;

    exp_t sb[$];
    exp_t pending;
    logic in_fire;
    logic out_fire;
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic z, input logic n, input logic c);
        exp_t e;
        e.data = d; e.zero = z; e.neg = n; e.carry = c; e.age = 0;
        return e;
    endfunction

    // Reference: shift rules expressed with plain 32-bit arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [3:0] k, input logic [15:0] d);
        int unsigned u;
        int unsigned r;
        int          kk;
        logic        c;
        u  = 32'(d);
        kk = int'(k);
        c  = 1'b0;
        case (op)
            2'b00: begin
                r = (u << kk) & 32'hFFFF;
                if (kk != 0) c = ((u >> (16 - kk)) & 1) != 0;
            end
            2'b01: begin
                r = u >> kk;
                if (kk != 0) c = ((u >> (kk - 1)) & 1) != 0;
            end
            2'b10: begin
                r = ((d[15] ? (u | 32'hFFFF0000) : u) >> kk) & 32'hFFFF;
                if (kk != 0) c = ((u >> (kk - 1)) & 1) != 0;
            end
            default: begin
                r = ((u >> kk) | (u << (16 - kk))) & 32'hFFFF;
                if (kk != 0) c = ((r >> 15) & 1) != 0;
            end
        endcase
        return mk(r[15:0], r[15:0] == 16'h0, r[15], c);
    endfunction

    // One clock: check outputs at the falling edge, update the model at the rising edge.
    task automatic step();
        logic exp_ready;
        logic exp_valid;
        @(negedge clk);
        in_fire  = 1'b0;
        out_fire = 1'b0;
        if (!reset) begin
            exp_ready = (sb.size() < 2) || out_ready;
            exp_valid = (sb.size() > 0) && (sb[0].age >= 2);
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid && out_valid) begin
                check("out_data", 32'(out_data), 32'(sb[0].data));
                check("out_zero", 32'(out_zero), 32'(sb[0].zero));
                check("out_neg", 32'(out_neg), 32'(sb[0].neg));
                check("out_carry", 32'(out_carry), 32'(sb[0].carry));
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
        end
        @(posedge clk);
        if (reset) begin
            sb.delete();
        end else begin
            if (out_fire && sb.size() > 0) void'(sb.pop_front());
            foreach (sb[i]) sb[i].age++;
            if (in_fire) begin
                pending.age = 1;
                sb.push_back(pending);
            end
        end
        #1;
    endtask

    // Offer one operation until accepted, with a bounded wait.
    task automatic issue(input logic [1:0] op, input logic [3:0] k, input logic [15:0] d,
                         input exp_t e, output int steps);
        in_valid = 1'b1;
        in_op    = op;
        in_shift = k;
        in_data  = d;
        pending  = e;
        steps    = 0;
        do begin
            step();
            steps++;
        end while (!in_fire && steps < 40);
        if (!in_fire) check("accept_timeout", 32'(in_fire), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            step();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  k;
        logic [15:0] d;
        logic [15:0] r;
        logic        z;
        logic        n;
        logic        c;
    } vec_t;

    vec_t vecs[6] = '{
        '{2'b10, 4'd4,  16'h8000, 16'hF800, 1'b0, 1'b1, 1'b0},
        '{2'b00, 4'd15, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0},
        '{2'b01, 4'd1,  16'h8001, 16'h4000, 1'b0, 1'b0, 1'b1},
        '{2'b11, 4'd1,  16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1},
        '{2'b10, 4'd0,  16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0},
        '{2'b01, 4'd1,  16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1}
    };

    initial begin
        int          steps;
        logic [1:0]  op;
        logic [3:0]  k;
        logic [15:0] d;
        logic [15:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_shift  = 4'd0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset values.
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_flags", {29'd0, out_zero, out_neg, out_carry}, 32'd0);

        // Directed known-answer cases, one at a time, with an exact latency check.
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].k, vecs[i].d,
                  mk(vecs[i].r, vecs[i].z, vecs[i].n, vecs[i].c), steps);
            step();
            check("latency_valid", 32'(out_valid), 32'd1);
            drain();
        end

        // Back-to-back stream of 8 operations, one accepted per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            k  = 4'($urandom_range(0, 15));
            d  = 16'($urandom);
            issue(op, k, d, model(op, k, d), steps);
            check("stream_one_cycle", 32'(steps), 32'd1);
        end
        drain();

        // Full backpressure: two held, third waits, then all three drain in order.
        out_ready = 1'b0;
        issue(2'b01, 4'd3, 16'hF0F0, model(2'b01, 4'd3, 16'hF0F0), steps);
        issue(2'b00, 4'd5, 16'h1357, model(2'b00, 4'd5, 16'h1357), steps);
        in_valid = 1'b1;
        in_op    = 2'b11;
        in_shift = 4'd7;
        in_data  = 16'hBEEF;
        pending  = model(2'b11, 4'd7, 16'hBEEF);
        step();
        held = out_data;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_no_accept", 32'(in_fire), 32'd0);
            check("stall_data_stable", 32'(out_data), 32'(held));
        end
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        issue(2'b11, 4'd7, 16'hBEEF, model(2'b11, 4'd7, 16'hBEEF), steps);
        drain();

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        issue(2'b10, 4'd2, 16'h9000, model(2'b10, 4'd2, 16'h9000), steps);
        issue(2'b00, 4'd1, 16'h0003, model(2'b00, 4'd1, 16'h0003), steps);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'h0);
        out_ready = 1'b1;
        issue(2'b01, 4'd4, 16'hABCD, model(2'b01, 4'd4, 16'hABCD), steps);
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_shift  = 4'($urandom_range(0, 15));
            in_data   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            pending   = model(in_op, in_shift, in_data);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
